// File: rtl/branch_history_table_if.sv
// Bus between the fetch/decode pipeline and the branch history table.
// master: pipeline side (issues lookups, updates, flush).
// slave:  table side (returns predictions and statistics).
interface branch_history_table_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CTR_W = 2,
  parameter int unsigned CNT_W = 16
);
  logic             flush;
  logic             lookup_valid;
  logic [PC_W-1:0]  lookup_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic [CTR_W-1:0] pred_state;
  logic [PC_W-1:0]  pred_target;
  logic             pred_hit;
  logic             update_valid;
  logic [PC_W-1:0]  update_pc;
  logic             update_taken;
  logic             update_pred;
  logic [PC_W-1:0]  update_target;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output flush, lookup_valid, lookup_pc,
    output update_valid, update_pc, update_taken, update_pred, update_target,
    input  pred_valid, pred_taken, pred_state, pred_target, pred_hit,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  flush, lookup_valid, lookup_pc,
    input  update_valid, update_pc, update_taken, update_pred, update_target,
    output pred_valid, pred_taken, pred_state, pred_target, pred_hit,
    output branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_history_table.sv
// PC-indexed table of saturating counters with registered prediction,
// write-first bypass from the same-cycle update, flush and mispredict stats.
// Optional BTB storage (valid/tag/target per entry) when BHT_BTB_EN is defined.
module branch_history_table #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CNT_W   = 16
) (
  input logic                    clk,
  input logic                    reset,
  branch_history_table_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] INIT    = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [CTR_W-1:0] ctr_d [ENTRIES];
  logic [CTR_W-1:0] up_old;
  logic [CTR_W-1:0] lk_ctr;
  logic             lk_hit;
  logic [PC_W-1:0]  lk_target;

  logic             pred_valid_q;
  logic             pred_taken_q;
  logic [CTR_W-1:0] pred_state_q;
  logic [CNT_W-1:0] branch_q;
  logic [CNT_W-1:0] mispredict_q;

  // Only the index (and tag, with BTB) bits of the PCs are consumed.
  logic unused_bits;
  assign unused_bits = ^{bus.lookup_pc, bus.update_pc, bus.update_target};

  assign lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign up_idx = bus.update_pc[IDX_W+1:2];

  // Next table state: saturating update, then flush overrides everything.
  always_comb begin
    up_old = ctr_q[up_idx];
    ctr_d  = ctr_q;
    if (bus.update_valid) begin
      if (bus.update_taken) begin
        ctr_d[up_idx] = (up_old == CTR_MAX) ? up_old : up_old + 1'b1;
      end else begin
        ctr_d[up_idx] = (up_old == '0) ? up_old : up_old - 1'b1;
      end
    end
    if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_d[i] = INIT;
      end
    end
  end

  // Reading the next-state array gives write-first bypass and flush-to-INIT for free.
  assign lk_ctr = ctr_d[lk_idx];

  // Counter table storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= INIT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

`ifdef BHT_BTB_EN
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  logic             val_q [ENTRIES];
  logic             val_d [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [TAG_W-1:0] tag_d [ENTRIES];
  logic [PC_W-1:0]  tgt_q [ENTRIES];
  logic [PC_W-1:0]  tgt_d [ENTRIES];
  logic             pred_hit_q;
  logic [PC_W-1:0]  pred_target_q;

  // Next BTB state: taken updates allocate; flush only drops valid bits.
  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    if (bus.update_valid && bus.update_taken) begin
      val_d[up_idx] = 1'b1;
      tag_d[up_idx] = bus.update_pc[PC_W-1:IDX_W+2];
      tgt_d[up_idx] = bus.update_target;
    end
    if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        val_d[i] = 1'b0;
      end
    end
  end

  assign lk_hit    = val_d[lk_idx] && (tag_d[lk_idx] == bus.lookup_pc[PC_W-1:IDX_W+2]);
  assign lk_target = lk_hit ? tgt_d[lk_idx] : '0;

  // BTB storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        val_q[i] <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      val_q <= val_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
    end
  end

  // Registered hit/target, held when no lookup is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_hit_q    <= 1'b0;
      pred_target_q <= '0;
    end else if (bus.lookup_valid) begin
      pred_hit_q    <= lk_hit;
      pred_target_q <= lk_target;
    end
  end

  assign bus.pred_hit    = pred_hit_q;
  assign bus.pred_target = pred_target_q;
`else
  assign lk_hit          = 1'b1;
  assign lk_target       = '0;
  assign bus.pred_hit    = 1'b1;
  assign bus.pred_target = '0;
`endif

  // Registered prediction; taken/state hold when no lookup is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_state_q <= INIT;
    end else begin
      pred_valid_q <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        pred_state_q <= lk_ctr;
        pred_taken_q <= lk_ctr[CTR_W-1] & lk_hit;
      end
    end
  end

  // Saturating statistics; updates are counted even when flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_q     <= '0;
      mispredict_q <= '0;
    end else if (bus.update_valid) begin
      if (branch_q != '1) begin
        branch_q <= branch_q + 1'b1;
      end
      if ((bus.update_pred != bus.update_taken) && (mispredict_q != '1)) begin
        mispredict_q <= mispredict_q + 1'b1;
      end
    end
  end

  assign bus.pred_valid       = pred_valid_q;
  assign bus.pred_taken       = pred_taken_q;
  assign bus.pred_state       = pred_state_q;
  assign bus.branch_count     = branch_q;
  assign bus.mispredict_count = mispredict_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table: directed scenarios plus a
// randomized run against an integer-arithmetic reference model. A second
// instance with 4-bit statistics exercises counter saturation.
module tb_branch_history_table;

  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int PC_W    = 32;
  localparam int CNT_W   = 16;
  localparam int CNT_W_S = 4;
  localparam int IDX_W   = 4;
  localparam int INIT    = 1;
  localparam int CMAX    = 3;
  localparam int SMAX    = 65535;
  localparam int SMAX_S  = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  branch_history_table_if #(.PC_W(PC_W), .CTR_W(CTR_W), .CNT_W(CNT_W))   bus   ();
  branch_history_table_if #(.PC_W(PC_W), .CTR_W(CTR_W), .CNT_W(CNT_W_S)) bus_s ();

  branch_history_table #(
    .ENTRIES(ENTRIES), .CTR_W(CTR_W), .PC_W(PC_W), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  branch_history_table #(
    .ENTRIES(ENTRIES), .CTR_W(CTR_W), .PC_W(PC_W), .CNT_W(CNT_W_S)
  ) dut_s (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_s)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: counters as plain integers, BTB as arrays.
  int          m_ctr [ENTRIES];
  bit          m_val [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_br, m_mp, m_br_s, m_mp_s;
  logic        exp_valid, exp_taken, exp_hit;
  logic [1:0]  exp_state;
  logic [31:0] exp_target;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_ctr[i] = INIT;
      m_val[i] = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
    end
    m_br = 0; m_mp = 0; m_br_s = 0; m_mp_s = 0;
    exp_valid  = 1'b0;
    exp_taken  = 1'b0;
    exp_state  = 2'(INIT);
    exp_target = '0;
`ifdef BHT_BTB_EN
    exp_hit = 1'b0;
`else
    exp_hit = 1'b1;
`endif
  endtask

  task automatic drive(input logic fl, input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic up, input logic [31:0] utgt);
    bus.flush = fl;          bus_s.flush = fl;
    bus.lookup_valid = lv;   bus_s.lookup_valid = lv;
    bus.lookup_pc = lpc;     bus_s.lookup_pc = lpc;
    bus.update_valid = uv;   bus_s.update_valid = uv;
    bus.update_pc = upc;     bus_s.update_pc = upc;
    bus.update_taken = ut;   bus_s.update_taken = ut;
    bus.update_pred = up;    bus_s.update_pred = up;
    bus.update_target = utgt; bus_s.update_target = utgt;
  endtask

  // One clock edge with the given inputs; afterwards exp_* hold the model's view.
  task automatic step(input logic fl, input logic lv, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic up, input logic [31:0] utgt);
    int ui;
    int li;
    bit hit;
    @(negedge clk);
    drive(fl, lv, lpc, uv, upc, ut, up, utgt);
    @(posedge clk);
    if (uv) begin
      ui = idx_of(upc);
      m_ctr[ui] = ut ? ((m_ctr[ui] < CMAX) ? m_ctr[ui] + 1 : CMAX)
                     : ((m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0);
      if (ut) begin
        m_val[ui] = 1'b1;
        m_tag[ui] = tag_of(upc);
        m_tgt[ui] = utgt;
      end
      m_br   = (m_br < SMAX) ? m_br + 1 : SMAX;
      m_br_s = (m_br_s < SMAX_S) ? m_br_s + 1 : SMAX_S;
      if (up != ut) begin
        m_mp   = (m_mp < SMAX) ? m_mp + 1 : SMAX;
        m_mp_s = (m_mp_s < SMAX_S) ? m_mp_s + 1 : SMAX_S;
      end
    end
    if (fl) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_ctr[i] = INIT;
        m_val[i] = 1'b0;
      end
    end
    exp_valid = lv;
    if (lv) begin
      li = idx_of(lpc);
`ifdef BHT_BTB_EN
      hit = m_val[li] && (m_tag[li] == tag_of(lpc));
      exp_target = hit ? m_tgt[li] : 32'h0;
`else
      hit = 1'b1;
      exp_target = 32'h0;
`endif
      exp_hit   = hit;
      exp_state = 2'(m_ctr[li]);
      exp_taken = (m_ctr[li] >= 2) && hit;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic look(input logic [31:0] pc);
    step(1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic ut, input logic up);
    step(1'b0, 1'b0, 32'h0, 1'b1, pc, ut, up, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.pred_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_valid: got %0b want 0", bus.pred_valid); end
    n_cmp++; if (bus.pred_state !== 2'(INIT)) begin n_fail++;
      $display("FAIL rst_state: got %0d want %0d", bus.pred_state, INIT); end
    n_cmp++; if (bus.pred_taken !== 1'b0) begin n_fail++;
      $display("FAIL rst_taken: got %0b want 0", bus.pred_taken); end
    look(32'h40);
    n_cmp++; if (bus.pred_valid !== 1'b1) begin n_fail++;
      $display("FAIL rst_lookup_valid: got %0b want 1", bus.pred_valid); end
    n_cmp++; if (bus.pred_state !== exp_state || bus.pred_taken !== exp_taken) begin n_fail++;
      $display("FAIL rst_lookup: got state %0d taken %0b want state %0d taken %0b",
               bus.pred_state, bus.pred_taken, exp_state, exp_taken); end
    n_cmp++; if (bus.branch_count !== 16'd0 || bus.mispredict_count !== 16'd0) begin n_fail++;
      $display("FAIL rst_stats: got %0d/%0d want 0/0", bus.branch_count,
               bus.mispredict_count); end
    // Asynchronous reset in the middle of a lookup.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.pred_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_async: got %0b want 0", bus.pred_valid); end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_cmp++; if (bus.pred_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_release_valid: got %0b want 0", bus.pred_valid); end
  endtask

  task automatic test_saturation();
    repeat (4) upd(32'h40, 1'b1, 1'b1);
    look(32'h40);
    n_cmp++; if (bus.pred_state !== exp_state || bus.pred_taken !== exp_taken) begin n_fail++;
      $display("FAIL sat_up: got state %0d taken %0b want state %0d taken %0b",
               bus.pred_state, bus.pred_taken, exp_state, exp_taken); end
    repeat (5) upd(32'h40, 1'b0, 1'b0);
    look(32'h40);
    n_cmp++; if (bus.pred_state !== exp_state || bus.pred_taken !== exp_taken) begin n_fail++;
      $display("FAIL sat_down: got state %0d taken %0b want state %0d taken %0b",
               bus.pred_state, bus.pred_taken, exp_state, exp_taken); end
  endtask

  task automatic test_alias();
    repeat (2) upd(32'h44, 1'b1, 1'b0);
    look(32'h44);
    n_cmp++; if (bus.pred_state !== exp_state) begin n_fail++;
      $display("FAIL alias_44: got %0d want %0d", bus.pred_state, exp_state); end
    look(32'h40);
    n_cmp++; if (bus.pred_state !== exp_state) begin n_fail++;
      $display("FAIL alias_40: got %0d want %0d", bus.pred_state, exp_state); end
    upd(32'h00, 1'b1, 1'b0);
    look(32'h83);
    n_cmp++; if (bus.pred_state !== exp_state) begin n_fail++;
      $display("FAIL alias_80: got %0d want %0d", bus.pred_state, exp_state); end
  endtask

  task automatic test_bypass();
    int br_before;
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h48, 1'b1, 32'h48, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (bus.pred_state !== exp_state || bus.pred_taken !== exp_taken) begin n_fail++;
      $display("FAIL bypass_same: got state %0d taken %0b want state %0d taken %0b",
               bus.pred_state, bus.pred_taken, exp_state, exp_taken); end
    step(1'b0, 1'b1, 32'h4C, 1'b1, 32'h48, 1'b1, 1'b1, 32'h0);
    n_cmp++; if (bus.pred_state !== exp_state) begin n_fail++;
      $display("FAIL bypass_diff: got %0d want %0d", bus.pred_state, exp_state); end
    br_before = int'(bus.branch_count);
    step(1'b1, 1'b1, 32'h48, 1'b1, 32'h48, 1'b1, 1'b1, 32'h0);
    n_cmp++; if (bus.pred_state !== exp_state || bus.pred_taken !== exp_taken) begin n_fail++;
      $display("FAIL bypass_flush: got state %0d taken %0b want state %0d taken %0b",
               bus.pred_state, bus.pred_taken, exp_state, exp_taken); end
    n_cmp++; if (int'(bus.branch_count) !== br_before + 1) begin n_fail++;
      $display("FAIL bypass_flush_count: got %0d want %0d", bus.branch_count,
               br_before + 1); end
  endtask

  task automatic test_stats();
    logic ut;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ut = 1'($urandom_range(0, 1));
      upd(32'($urandom_range(0, 255)) << 2, ut, (i == 2 || i == 5 || i == 7) ? ~ut : ut);
    end
    n_cmp++; if (int'(bus.branch_count) !== m_br || int'(bus.mispredict_count) !== m_mp)
      begin n_fail++;
      $display("FAIL stats_10: got %0d/%0d want %0d/%0d", bus.branch_count,
               bus.mispredict_count, m_br, m_mp); end
    n_cmp++; if (int'(bus_s.branch_count) !== m_br_s ||
                 int'(bus_s.mispredict_count) !== m_mp_s) begin n_fail++;
      $display("FAIL stats_10_small: got %0d/%0d want %0d/%0d", bus_s.branch_count,
               bus_s.mispredict_count, m_br_s, m_mp_s); end
    for (int i = 0; i < 10; i++) begin
      upd(32'($urandom_range(0, 255)) << 2, 1'b1, 1'b1);
    end
    n_cmp++; if (int'(bus.branch_count) !== m_br) begin n_fail++;
      $display("FAIL stats_20: got %0d want %0d", bus.branch_count, m_br); end
    n_cmp++; if (int'(bus_s.branch_count) !== m_br_s) begin n_fail++;
      $display("FAIL stats_sat_small: got %0d want %0d", bus_s.branch_count, m_br_s); end
  endtask

  task automatic test_btb();
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200);
    look(32'h100);
    n_cmp++; if (bus.pred_hit !== exp_hit || bus.pred_target !== exp_target) begin n_fail++;
      $display("FAIL btb_hit: got hit %0b tgt %h want hit %0b tgt %h",
               bus.pred_hit, bus.pred_target, exp_hit, exp_target); end
    look(32'h500);
    n_cmp++; if (bus.pred_hit !== exp_hit || bus.pred_target !== exp_target ||
                 bus.pred_taken !== exp_taken) begin n_fail++;
      $display("FAIL btb_miss: got hit %0b tgt %h taken %0b want hit %0b tgt %h taken %0b",
               bus.pred_hit, bus.pred_target, bus.pred_taken, exp_hit, exp_target,
               exp_taken); end
  endtask

  task automatic test_random();
    logic [31:0] lpc, upc;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      lpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
      upc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), lpc,
           1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom);
      n_cmp++; if (bus.pred_valid !== exp_valid || bus.pred_state !== exp_state ||
                   bus.pred_taken !== exp_taken || bus.pred_hit !== exp_hit ||
                   bus.pred_target !== exp_target) begin n_fail++;
        $display("FAIL rnd_pred[%0d]: got v%0b s%0d t%0b h%0b %h want v%0b s%0d t%0b h%0b %h",
                 n, bus.pred_valid, bus.pred_state, bus.pred_taken, bus.pred_hit,
                 bus.pred_target, exp_valid, exp_state, exp_taken, exp_hit, exp_target); end
      n_cmp++; if (int'(bus.branch_count) !== m_br || int'(bus.mispredict_count) !== m_mp ||
                   int'(bus_s.branch_count) !== m_br_s ||
                   int'(bus_s.mispredict_count) !== m_mp_s) begin n_fail++;
        $display("FAIL rnd_stats[%0d]: got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d", n,
                 bus.branch_count, bus.mispredict_count, bus_s.branch_count,
                 bus_s.mispredict_count, m_br, m_mp, m_br_s, m_mp_s); end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    model_reset();
    test_reset();
    test_saturation();
    test_alias();
    test_bypass();
    test_stats();
    test_btb();
    test_random();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
